// File: rtl/axi_read_resp_router_if.sv
// Signal bundle between the read-response router and its environment
// (arbiter, slaves, masters); the slave modport is the router's view.
interface axi_read_resp_router_if #(
  parameter int NS = 5,
  parameter int DW = 32
);
  logic [1:0]       rd_grant;
  logic [2:0]       rd_sel;
  logic             ar_fire;
  logic [3:0]       ar_len;
  logic [NS*DW-1:0] RDATA_S;
  logic [NS*2-1:0]  RRESP_S;
  logic [NS-1:0]    RLAST_S;
  logic [NS-1:0]    RVALID_S;
  logic [NS-1:0]    RREADY_S;
  logic [DW-1:0]    RDATA_M0;
  logic [DW-1:0]    RDATA_M1;
  logic [1:0]       RRESP_M0;
  logic [1:0]       RRESP_M1;
  logic             RLAST_M0;
  logic             RLAST_M1;
  logic             RVALID_M0;
  logic             RVALID_M1;
  logic             RREADY_M0;
  logic             RREADY_M1;
  logic             rd_busy;
  logic             burst_err;

  modport slave (
    input  rd_grant, rd_sel, ar_fire, ar_len,
    input  RDATA_S, RRESP_S, RLAST_S, RVALID_S,
    output RREADY_S,
    output RDATA_M0, RDATA_M1, RRESP_M0, RRESP_M1,
    output RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1,
    input  RREADY_M0, RREADY_M1,
    output rd_busy, burst_err
  );

  modport master (
    output rd_grant, rd_sel, ar_fire, ar_len,
    output RDATA_S, RRESP_S, RLAST_S, RVALID_S,
    input  RREADY_S,
    input  RDATA_M0, RDATA_M1, RRESP_M0, RRESP_M1,
    input  RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1,
    output RREADY_M0, RREADY_M1,
    input  rd_busy, burst_err
  );
endinterface

// File: rtl/axi_read_resp_router.sv
// Routes the granted slave's R channel to the owning master (zero latency),
// answers unmapped reads with DECERR bursts, and flags RLAST/ARLEN mismatches.
module axi_read_resp_router #(
  parameter int NS = 5,
  parameter int DW = 32
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  axi_read_resp_router_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ROUTE, DECERR} state_t;

  state_t        state, state_nxt;
  logic [1:0]    owner;
  logic [2:0]    sel;
  logic [3:0]    len;
  logic [3:0]    beat;
  logic          burst_err_q;

  logic          grant_ok, sel_real, accept;
  logic          own_m0, own_rdy, hs;
  logic [DW-1:0] r_dat;
  logic [1:0]    r_resp;
  logic          r_last, r_vld;

  assign grant_ok = (bus.rd_grant == 2'b01) || (bus.rd_grant == 2'b10);
  assign sel_real = ({29'd0, bus.rd_sel} < NS);
  assign accept   = (state == IDLE) && bus.ar_fire && grant_ok;
  assign own_m0   = (owner == 2'b01);
  assign own_rdy  = own_m0 ? bus.RREADY_M0 : bus.RREADY_M1;
  assign hs       = r_vld & own_rdy;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state       <= IDLE;
      owner       <= '0;
      sel         <= '0;
      len         <= '0;
      beat        <= '0;
      burst_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner <= bus.rd_grant;
        sel   <= bus.rd_sel;
        len   <= bus.ar_len;
        beat  <= '0;
      end else if (hs) begin
        beat <= beat + 4'd1;
      end
      // A routed beat is wrong exactly when RLAST and "this is beat len" disagree.
      if ((state == ROUTE) && hs && (r_last != (beat == len)))
        burst_err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:          if (accept) state_nxt = sel_real ? ROUTE : DECERR;
      ROUTE, DECERR: if (hs && r_last) state_nxt = IDLE;
      default:       state_nxt = IDLE;
    endcase
  end

  always_comb begin
    r_dat         = '0;
    r_resp        = '0;
    r_last        = 1'b0;
    r_vld         = 1'b0;
    bus.RREADY_S  = '0;
    bus.RDATA_M0  = '0;
    bus.RRESP_M0  = '0;
    bus.RLAST_M0  = 1'b0;
    bus.RVALID_M0 = 1'b0;
    bus.RDATA_M1  = '0;
    bus.RRESP_M1  = '0;
    bus.RLAST_M1  = 1'b0;
    bus.RVALID_M1 = 1'b0;
    case (state)
      ROUTE: begin
        for (int i = 0; i < NS; i++) begin
          if (sel == 3'(i)) begin
            r_dat           = bus.RDATA_S[i*DW +: DW];
            r_resp          = bus.RRESP_S[i*2 +: 2];
            r_last          = bus.RLAST_S[i];
            r_vld           = bus.RVALID_S[i];
            bus.RREADY_S[i] = own_rdy;
          end
        end
      end
      DECERR: begin
        r_vld  = 1'b1;
        r_resp = 2'b11;
        r_last = (beat == len);
      end
      default: ;
    endcase
    if (state != IDLE) begin
      if (own_m0) begin
        bus.RDATA_M0  = r_dat;
        bus.RRESP_M0  = r_resp;
        bus.RLAST_M0  = r_last;
        bus.RVALID_M0 = r_vld;
      end else begin
        bus.RDATA_M1  = r_dat;
        bus.RRESP_M1  = r_resp;
        bus.RLAST_M1  = r_last;
        bus.RVALID_M1 = r_vld;
      end
    end
  end

  assign bus.rd_busy   = (state != IDLE);
  assign bus.burst_err = burst_err_q;

endmodule

// File: tb/tb_axi_read_resp_router.sv
// Directed bench for axi_read_resp_router: single read, backpressured burst,
// default slave, early RLAST, reset mid-burst and ignored ar_fire.
module tb_axi_read_resp_router;

  logic ACLK;
  logic ARESETn;
  int   total;
  int   passed;

  axi_read_resp_router_if #(.NS(5), .DW(32)) bus ();

  axi_read_resp_router #(.NS(5), .DW(32)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.rd_grant  = 2'b00;
    bus.rd_sel    = 3'd0;
    bus.ar_fire   = 1'b0;
    bus.ar_len    = 4'd0;
    bus.RDATA_S   = '0;
    bus.RRESP_S   = '0;
    bus.RLAST_S   = '0;
    bus.RVALID_S  = '0;
    bus.RREADY_M0 = 1'b0;
    bus.RREADY_M1 = 1'b0;
  endtask

  task automatic slave_drive(input int s, input logic vld, input logic last,
                             input logic [31:0] d, input logic [1:0] r);
    bus.RDATA_S  = '0;
    bus.RRESP_S  = '0;
    bus.RLAST_S  = '0;
    bus.RVALID_S = '0;
    bus.RDATA_S[s*32 +: 32] = d;
    bus.RRESP_S[s*2 +: 2]   = r;
    bus.RLAST_S[s]          = last;
    bus.RVALID_S[s]         = vld;
  endtask

  // Presents one AR handshake; grant/sel/len are removed afterwards so only latched values matter.
  task automatic issue_ar(input logic [1:0] g, input logic [2:0] s, input logic [3:0] l);
    bus.rd_grant = g;
    bus.rd_sel   = s;
    bus.ar_len   = l;
    bus.ar_fire  = 1'b1;
    tick();
    bus.ar_fire  = 1'b0;
    bus.rd_grant = 2'b00;
    bus.rd_sel   = 3'd0;
    bus.ar_len   = 4'd0;
  endtask

  task automatic test_reset();
    clear_inputs();
    ARESETn = 1'b0;
    bus.RVALID_S  = 5'b11111;
    bus.RREADY_M0 = 1'b1;
    tick();
    tick();
    @(negedge ACLK);
    total++;
    if (bus.rd_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.rd_busy); else passed++;
    total++;
    if (bus.burst_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", bus.burst_err); else passed++;
    total++;
    if ({bus.RVALID_M0, bus.RVALID_M1, bus.RLAST_M0, bus.RLAST_M1} !== 4'b0)
      $display("FAIL reset_rvalid got=%b exp=0000",
               {bus.RVALID_M0, bus.RVALID_M1, bus.RLAST_M0, bus.RLAST_M1});
    else passed++;
    total++;
    if (bus.RREADY_S !== 5'b0) $display("FAIL reset_rready_s got=%b exp=00000", bus.RREADY_S); else passed++;
    tick();
    ARESETn = 1'b1;
    clear_inputs();
    tick();
  endtask

  task automatic test_single();
    issue_ar(2'b01, 3'd1, 4'd0);
    slave_drive(1, 1'b1, 1'b1, 32'hDEADBEEF, 2'b00);
    bus.RREADY_M0 = 1'b1;
    @(negedge ACLK);
    total++;
    if (bus.RDATA_M0 !== 32'hDEADBEEF) $display("FAIL single_rdata got=%h exp=deadbeef", bus.RDATA_M0); else passed++;
    total++;
    if ({bus.RVALID_M0, bus.RLAST_M0} !== 2'b11)
      $display("FAIL single_vld_last got=%b exp=11", {bus.RVALID_M0, bus.RLAST_M0});
    else passed++;
    total++;
    if (bus.RREADY_S !== 5'b00010) $display("FAIL single_rready_s got=%b exp=00010", bus.RREADY_S); else passed++;
    total++;
    if (bus.RVALID_M1 !== 1'b0) $display("FAIL single_m1_quiet got=%b exp=0", bus.RVALID_M1); else passed++;
    tick();
    clear_inputs();
    @(negedge ACLK);
    total++;
    if (bus.rd_busy !== 1'b0) $display("FAIL single_idle got=%b exp=0", bus.rd_busy); else passed++;
    total++;
    if (bus.burst_err !== 1'b0) $display("FAIL single_err got=%b exp=0", bus.burst_err); else passed++;
    tick();
  endtask

  task automatic test_burst_backpressure();
    logic [4:0] rdy_pat;
    int sb;
    int hs_seen;
    rdy_pat = 5'b11101;   // bit c = RREADY_M1 in cycle c: 1,0,1,1,1
    sb      = 0;
    hs_seen = 0;
    issue_ar(2'b10, 3'd4, 4'd3);
    for (int c = 0; c < 5; c++) begin
      slave_drive(4, 1'b1, (sb == 3), 32'h100 + sb, 2'b01);
      bus.RREADY_M1 = rdy_pat[c];
      @(negedge ACLK);
      total++;
      if (bus.RDATA_M1 !== 32'h100 + sb)
        $display("FAIL burst_rdata c=%0d got=%h exp=%h", c, bus.RDATA_M1, 32'h100 + sb);
      else passed++;
      total++;
      if (bus.RLAST_M1 !== (sb == 3))
        $display("FAIL burst_rlast c=%0d got=%b exp=%b", c, bus.RLAST_M1, (sb == 3));
      else passed++;
      total++;
      if ({bus.RVALID_M0, bus.RLAST_M0, bus.RRESP_M0, bus.RDATA_M0} !== 36'd0)
        $display("FAIL burst_m0_quiet c=%0d got=%h exp=0", c,
                 {bus.RVALID_M0, bus.RLAST_M0, bus.RRESP_M0, bus.RDATA_M0});
      else passed++;
      total++;
      if ({bus.RVALID_M1, bus.RRESP_M1, bus.RREADY_S} !== {1'b1, 2'b01, rdy_pat[c], 4'b0000})
        $display("FAIL burst_vld_resp_rdy c=%0d got=%b exp=%b", c,
                 {bus.RVALID_M1, bus.RRESP_M1, bus.RREADY_S}, {1'b1, 2'b01, rdy_pat[c], 4'b0000});
      else passed++;
      if (rdy_pat[c]) begin
        sb++;
        hs_seen++;
      end
      tick();
    end
    clear_inputs();
    @(negedge ACLK);
    total++;
    if (hs_seen !== 4) $display("FAIL burst_hs_count got=%0d exp=4", hs_seen); else passed++;
    total++;
    if ({bus.rd_busy, bus.burst_err} !== 2'b00)
      $display("FAIL burst_end got=%b exp=00", {bus.rd_busy, bus.burst_err});
    else passed++;
    tick();
  endtask

  task automatic test_default_slave();
    issue_ar(2'b01, 3'd7, 4'd2);
    // Stray slave activity must neither reach M0 nor be acknowledged.
    bus.RVALID_S = 5'b11111;
    bus.RLAST_S  = 5'b11111;
    bus.RDATA_S  = {5{32'hA5A5A5A5}};
    bus.RREADY_M0 = 1'b0;
    @(negedge ACLK);
    total++;
    if ({bus.RVALID_M0, bus.RLAST_M0} !== 2'b10)
      $display("FAIL decerr_stall got=%b exp=10", {bus.RVALID_M0, bus.RLAST_M0});
    else passed++;
    tick();
    bus.RREADY_M0 = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(negedge ACLK);
      total++;
      if ({bus.RVALID_M0, bus.RRESP_M0, bus.RLAST_M0} !== {1'b1, 2'b11, (b == 2)})
        $display("FAIL decerr_beat b=%0d got=%b exp=%b", b,
                 {bus.RVALID_M0, bus.RRESP_M0, bus.RLAST_M0}, {1'b1, 2'b11, (b == 2)});
      else passed++;
      total++;
      if ({bus.RDATA_M0, bus.RREADY_S} !== 37'd0)
        $display("FAIL decerr_data_rdy b=%0d got=%h exp=0", b, {bus.RDATA_M0, bus.RREADY_S});
      else passed++;
      tick();
    end
    clear_inputs();
    @(negedge ACLK);
    total++;
    if ({bus.rd_busy, bus.burst_err, bus.RVALID_M0} !== 3'b000)
      $display("FAIL decerr_end got=%b exp=000", {bus.rd_busy, bus.burst_err, bus.RVALID_M0});
    else passed++;
    tick();
  endtask

  task automatic test_early_rlast();
    issue_ar(2'b10, 3'd2, 4'd3);
    bus.RREADY_M1 = 1'b1;
    slave_drive(2, 1'b1, 1'b0, 32'h11, 2'b00);
    tick();
    slave_drive(2, 1'b1, 1'b1, 32'h22, 2'b00);
    @(negedge ACLK);
    total++;
    if ({bus.RLAST_M1, bus.RDATA_M1} !== {1'b1, 32'h22})
      $display("FAIL early_last_beat got=%h exp=%h", {bus.RLAST_M1, bus.RDATA_M1}, {1'b1, 32'h22});
    else passed++;
    tick();
    clear_inputs();
    @(negedge ACLK);
    total++;
    if ({bus.rd_busy, bus.burst_err} !== 2'b01)
      $display("FAIL early_err got=%b exp=01", {bus.rd_busy, bus.burst_err});
    else passed++;
    tick();
    issue_ar(2'b01, 3'd0, 4'd0);
    slave_drive(0, 1'b1, 1'b1, 32'h33, 2'b00);
    bus.RREADY_M0 = 1'b1;
    @(negedge ACLK);
    total++;
    if (bus.RDATA_M0 !== 32'h33) $display("FAIL early_clean_data got=%h exp=33", bus.RDATA_M0); else passed++;
    tick();
    clear_inputs();
    @(negedge ACLK);
    total++;
    if ({bus.rd_busy, bus.burst_err} !== 2'b01)
      $display("FAIL early_sticky got=%b exp=01", {bus.rd_busy, bus.burst_err});
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    issue_ar(2'b01, 3'd3, 4'd3);
    bus.RREADY_M0 = 1'b1;
    slave_drive(3, 1'b1, 1'b0, 32'h44, 2'b00);
    tick();
    ARESETn = 1'b0;
    slave_drive(3, 1'b1, 1'b0, 32'h55, 2'b00);
    tick();
    ARESETn = 1'b1;
    @(negedge ACLK);
    total++;
    if ({bus.rd_busy, bus.burst_err} !== 2'b00)
      $display("FAIL rstmid_state got=%b exp=00", {bus.rd_busy, bus.burst_err});
    else passed++;
    total++;
    if ({bus.RVALID_M0, bus.RDATA_M0, bus.RREADY_S} !== 38'd0)
      $display("FAIL rstmid_outputs got=%h exp=0", {bus.RVALID_M0, bus.RDATA_M0, bus.RREADY_S});
    else passed++;
    clear_inputs();
    tick();
    issue_ar(2'b10, 3'd0, 4'd0);
    slave_drive(0, 1'b1, 1'b1, 32'h66, 2'b00);
    bus.RREADY_M1 = 1'b1;
    @(negedge ACLK);
    total++;
    if ({bus.RVALID_M1, bus.RLAST_M1, bus.RDATA_M1, bus.RREADY_S} !== {2'b11, 32'h66, 5'b00001})
      $display("FAIL rstmid_fresh got=%h exp=%h", {bus.RVALID_M1, bus.RLAST_M1, bus.RDATA_M1, bus.RREADY_S},
               {2'b11, 32'h66, 5'b00001});
    else passed++;
    tick();
    clear_inputs();
    @(negedge ACLK);
    total++;
    if (bus.rd_busy !== 1'b0) $display("FAIL rstmid_fresh_idle got=%b exp=0", bus.rd_busy); else passed++;
    tick();
  endtask

  task automatic test_ignored_fire();
    bus.rd_grant = 2'b00; bus.rd_sel = 3'd1; bus.ar_fire = 1'b1;
    tick();
    bus.rd_grant = 2'b11;
    tick();
    bus.ar_fire = 1'b0;
    @(negedge ACLK);
    total++;
    if (bus.rd_busy !== 1'b0) $display("FAIL ignored_grant got=%b exp=0", bus.rd_busy); else passed++;
    tick();
    issue_ar(2'b01, 3'd2, 4'd1);
    // A second fire mid-burst must not move owner, sel or len.
    issue_ar(2'b10, 3'd7, 4'd0);
    bus.RREADY_M0 = 1'b1;
    bus.RREADY_M1 = 1'b1;
    slave_drive(2, 1'b1, 1'b0, 32'h77, 2'b00);
    @(negedge ACLK);
    total++;
    if ({bus.RVALID_M0, bus.RVALID_M1, bus.RDATA_M0, bus.RREADY_S} !== {2'b10, 32'h77, 5'b00100})
      $display("FAIL ignored_owner got=%h exp=%h", {bus.RVALID_M0, bus.RVALID_M1, bus.RDATA_M0, bus.RREADY_S},
               {2'b10, 32'h77, 5'b00100});
    else passed++;
    tick();
    slave_drive(2, 1'b1, 1'b1, 32'h88, 2'b00);
    tick();
    clear_inputs();
    @(negedge ACLK);
    total++;
    if ({bus.rd_busy, bus.burst_err} !== 2'b00)
      $display("FAIL ignored_len got=%b exp=00", {bus.rd_busy, bus.burst_err});
    else passed++;
    tick();
  endtask

  initial begin
    total   = 0;
    passed  = 0;
    ARESETn = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_burst_backpressure();
    test_default_slave();
    test_early_rlast();
    test_reset_mid_burst();
    test_ignored_fire();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
